// File: rtl/bus_cycle_ctrl.sv
// Bus cycle controller: accepts one CPU request at a time, decodes it onto one of
// two memory banks or two IO windows, strobes WD/OE, and returns a one-cycle response.
module bus_cycle_ctrl #(
    parameter int unsigned IO_WAIT       = 0,
    parameter logic [7:0]  UNMAPPED_DATA = 8'hFF
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [19:0] req_addr,
    input  logic        req_io,
    input  logic        req_wr,
    input  logic [7:0]  req_wdata,
    output logic        rsp_valid,
    output logic [7:0]  rsp_rdata,
    output logic        rsp_err,
    output logic [19:0] Add_Reg,
    output logic [3:0]  WD,
    output logic [3:0]  OE,
    output logic [7:0]  wr_data,
    output logic        wr_en,
    input  logic [7:0]  rd_data
);

    localparam logic [3:0] IoWait = 4'(IO_WAIT);

    typedef enum logic [1:0] {StIdle, StAccess, StRead, StResp} state_e;

    state_e      state_q;
    logic [19:0] add_reg_q;
    logic [7:0]  wr_data_q;
    logic        wr_q;
    logic [3:0]  sel_q;
    logic        err_q;
    logic [3:0]  wait_q;
    logic        req_ready_q;
    logic [3:0]  wd_q;
    logic [3:0]  oe_q;
    logic        wr_en_q;
    logic        rsp_valid_q;
    logic [7:0]  rsp_rdata_q;
    logic        rsp_err_q;

    logic [3:0]  sel_d;
    logic        err_d;
    logic [3:0]  wait_d;

    // Target decode of the incoming request; only consumed on the handshake edge.
    always_comb begin
        sel_d  = 4'b0000;
        err_d  = 1'b0;
        wait_d = req_io ? IoWait : 4'd0;
        if (!req_io) begin
            sel_d = req_addr[19] ? 4'b0010 : 4'b0001;
        end else if (req_addr >= 20'h0FF00 && req_addr <= 20'h0FF0F) begin
            sel_d = 4'b0100;
        end else if (req_addr >= 20'h01C00 && req_addr <= 20'h01D00) begin
            sel_d = 4'b1000;
        end else begin
            err_d = 1'b1;
        end
    end

    // Transaction FSM with all bus strobes and response outputs registered.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= StIdle;
            add_reg_q   <= 20'h0;
            wr_data_q   <= 8'h0;
            wr_q        <= 1'b0;
            sel_q       <= 4'b0000;
            err_q       <= 1'b0;
            wait_q      <= 4'd0;
            req_ready_q <= 1'b1;
            wd_q        <= 4'b0000;
            oe_q        <= 4'b0000;
            wr_en_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 8'h0;
            rsp_err_q   <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (req_valid && req_ready_q) begin
                        add_reg_q   <= req_addr;
                        wr_data_q   <= req_wdata;
                        wr_q        <= req_wr;
                        sel_q       <= sel_d;
                        err_q       <= err_d;
                        wait_q      <= wait_d;
                        req_ready_q <= 1'b0;
                        state_q     <= StAccess;
                        // Write strobe is raised for the whole ACCESS phase of a mapped write.
                        if (req_wr && !err_d) begin
                            wd_q    <= sel_d;
                            wr_en_q <= 1'b1;
                        end
                    end
                end
                StAccess: begin
                    if (wait_q != 4'd0) begin
                        wait_q <= wait_q - 4'd1;
                    end else begin
                        wd_q    <= 4'b0000;
                        wr_en_q <= 1'b0;
                        if (!wr_q && !err_q) begin
                            oe_q    <= sel_q;
                            state_q <= StRead;
                        end else begin
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= err_q;
                            if (!wr_q) begin
                                rsp_rdata_q <= UNMAPPED_DATA;
                            end
                            state_q <= StResp;
                        end
                    end
                end
                StRead: begin
                    // Slave's read register is on rd_data while OE is high.
                    oe_q        <= 4'b0000;
                    rsp_rdata_q <= rd_data;
                    rsp_valid_q <= 1'b1;
                    rsp_err_q   <= 1'b0;
                    state_q     <= StResp;
                end
                StResp: begin
                    rsp_valid_q <= 1'b0;
                    rsp_err_q   <= 1'b0;
                    req_ready_q <= 1'b1;
                    state_q     <= StIdle;
                end
                default: begin
                    state_q     <= StIdle;
                    req_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign Add_Reg   = add_reg_q;
    assign WD        = wd_q;
    assign OE        = oe_q;
    assign wr_data   = wr_data_q;
    assign wr_en     = wr_en_q;

endmodule

// File: doc/bus_cycle_ctrl.md
# bus_cycle_ctrl

Bus cycle controller sitting directly upstream of the four memory/IO slave blocks: two 512 KiB memory banks and two IO register windows. It accepts one CPU-side request at a time over a valid/ready handshake and decodes the 20-bit address plus memory/IO space into a single target. It drives the shared `Add_Reg`/data bus and per-target `WD`/`OE` strobes, sequences the slaves' one-cycle registered read latency, and returns read data or an error on a one-cycle response pulse.

## Interface
- `IO_WAIT`, 0: extra ACCESS cycles inserted for IO-space targets (0–15).
- `UNMAPPED_DATA`, 8'hFF: `rsp_rdata` value returned for unmapped reads.
- `CLK` in 1: single clock, all state updates on rising edge.
- `RST` in 1: synchronous, active-high reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: high only in IDLE; transfer occurs when `req_valid && req_ready` at a rising edge.
- `req_addr` in 20: byte address.
- `req_io` in 1: 1 = IO space, 0 = memory space.
- `req_wr` in 1: 1 = write, 0 = read.
- `req_wdata` in 8: write data.
- `rsp_valid` out 1: one-cycle completion pulse.
- `rsp_rdata` out 8: read data, valid with `rsp_valid`; held until next response.
- `rsp_err` out 1: unmapped access, valid with `rsp_valid`.
- `Add_Reg` out 20: registered address to all slaves.
- `WD` out 4: per-target write strobe. Bit 0 = Mem1, 1 = Mem2, 2 = IO1, 3 = IO2.
- `OE` out 4: per-target output enable, same bit order.
- `wr_data` out 8: write data onto the shared slave data bus.
- `wr_en` out 1: drive enable for `wr_data`. The bus is tri-stated when low.
- `rd_data` in 8: resolved slave `tri_buff` bus.

## Operation
- Decode on the captured request:
  - Memory space: `addr[19]`=0 selects Mem1 (0x00000–0x7FFFF); `addr[19]`=1 selects Mem2 (0x80000–0xFFFFF). Memory space is never unmapped.
  - IO space: 0x0FF00–0x0FF0F selects IO1; 0x01C00–0x01D00 inclusive selects IO2. Any other IO address is unmapped. Bits [19:16] take part in the compare.
- States:
  - IDLE: `req_ready`=1. On handshake: latch `Add_Reg`, write data, wr flag, target select, error flag, and wait count (`IO_WAIT` for IO targets, else 0). Go to ACCESS.
  - ACCESS: for a mapped write, `WD[sel]`=1 and `wr_en`=1 on every cycle here. For a read, no strobes; the slave captures its read register at each edge. Wait counter decrements while nonzero. When it reaches 0, go to READ (mapped read) or RESP (write or unmapped).
  - READ: `OE[sel]`=1, one cycle. `rsp_rdata` <= `rd_data` at the end edge. Go to RESP.
  - RESP: `rsp_valid`=1, `rsp_err`=error flag, one cycle. Go to IDLE.
- Unmapped access: no `WD`/`OE`/`wr_en` ever asserted. `rsp_err`=1. For reads, `rsp_rdata`=`UNMAPPED_DATA`. Writes leave `rsp_rdata` unchanged.
- Request inputs are ignored outside the handshake cycle; changes after acceptance have no effect.
- At most one `WD` bit and one `OE` bit is high in any cycle. `WD` and `OE` are never high together.

## Timing
- Reset values: state IDLE, `req_ready`=1, `Add_Reg`=0, `WD`=0, `OE`=0, `wr_en`=0, `wr_data`=0, `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0.
- With handshake at edge k and wait count W:
  - Write: ACCESS cycles k+1 … k+1+W; `rsp_valid` in cycle k+2+W.
  - Read: READ in cycle k+2+W; `rsp_valid` in cycle k+3+W.
  - Unmapped: `rsp_valid` in cycle k+2+W.
- No pipelining. The next handshake occurs no earlier than the edge after RESP, so minimum spacing is 3 cycles for memory writes and 4 cycles for memory reads.
- `Add_Reg` changes only at a handshake edge and is stable for the whole transaction and through the following IDLE.
- `RST` is sampled at every edge and overrides everything. Mid-transaction, all strobes drop at that edge, the transaction is aborted, and no response is produced. A `req_valid` coinciding with `RST` is not accepted.

## Test plan
- Write Mem1 0x00010 ← 0xA5, then read 0x00010 → `WD`=0001 for 1 cycle, `rsp_valid` at k+2; read gives `OE`=0001 in READ and `rsp_rdata`=0xA5 at k+3, `rsp_err`=0.
- Decode boundaries in memory space: 0x7FFFF selects bit 0 and 0x80000 selects bit 1. Write 0x3C to 0x80000 and read it back as 0x3C.
- `IO_WAIT`=2, write IO1 0x0FF0F ← 0x5A → `WD[2]` high for 3 cycles, `rsp_valid` at k+4. Read back → 0x5A with `rsp_valid` at k+5.
- IO2 boundaries: 0x01D00 maps to bit 3. IO reads of 0x01D01 and 0x0FF10 → no strobes, `rsp_err`=1, `rsp_rdata`=0xFF. Unmapped write → `rsp_err`=1, no `wr_en`.
- Assert `RST` during the READ cycle of a Mem2 read → `OE`=0 next cycle, no `rsp_valid`, `req_ready`=1. A fresh read then completes normally.
- Hold `req_valid` high continuously with changing `req_addr` → accepts occur only in IDLE. Each response matches the address captured at its own handshake.
